// File: rtl/aes_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand
//
// Sequential AES-128 key-schedule engine. A start request captures the cipher
// key, then the 11 round keys (rounds 0..10) are offered one at a time over a
// valid/ready interface to the AddRoundKey stage downstream.
//
// The next round key is derived combinationally from the current one:
//   t   = SubWord(RotWord(w3)) ^ Rcon(r),   r = rk_round + 1
//   w0' = w0 ^ t, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'
// The byte S-box and the round-constant table are local functions, so the
// block has no external dependencies.
//
// Optional build macro:
//   AES_KEYEXP_PIPE_EN - registers t after SubWord/Rcon. Each non-final
//                        transfer then spends one cycle in PIPE_WAIT with
//                        rk_valid low (one key per two cycles).
//
// Ports:
//   clk        in   1    system clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    request a new expansion (sampled only in IDLE)
//   key        in   128  cipher key, byte 0 in [127:120]
//   rk_valid   out  1    round_key / rk_round valid
//   rk_ready   in   1    consumer accepts the current round key
//   round_key  out  128  current round key, w0 in [127:96]
//   rk_round   out  4    round index of round_key, 0..10
//   busy       out  1    high from start acceptance until the final handshake
//   done       out  1    one-cycle pulse after the round-10 key is accepted
// -----------------------------------------------------------------------------
module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT      = 2'd1
`ifdef AES_KEYEXP_PIPE_EN
        ,
        PIPE_WAIT = 2'd2
`endif
    } state_t;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse (a^254, which maps 0 to 0) followed
    // by the affine transform written as rotate-XORs plus 0x63.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Round constant word for rounds 1..10; other indices are never used.
    function automatic logic [31:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

    state_t         state_reg, state_next;
    logic [127:0]   key_reg;
    logic [3:0]     round_reg;
    logic           done_reg;

    logic           xfer;
    logic           last;
    logic [3:0]     rcon_idx;
    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    rot_word;
    logic [31:0]    sub_word;
    logic [31:0]    t_comb;
    logic [31:0]    t_use;
    logic [31:0]    n0, n1, n2, n3;
    logic [127:0]   key_next;

    assign xfer     = (state_reg == EMIT) && rk_ready;
    assign last     = (round_reg == LAST_ROUND);
    assign rcon_idx = round_reg + 4'd1;

    assign {w0, w1, w2, w3} = key_reg;
    assign rot_word = {w3[23:0], w3[31:24]};

    // SubWord: four S-box lanes
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            assign sub_word[gi*8 +: 8] = sbox(rot_word[gi*8 +: 8]);
        end
    endgenerate

    assign t_comb = sub_word ^ rcon(rcon_idx);

`ifdef AES_KEYEXP_PIPE_EN
    // t is captured on the transfer and applied one cycle later in PIPE_WAIT,
    // while key_reg and round_reg still hold the key it was derived from.
    logic [31:0] t_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_reg <= 32'h0;
        end else if (xfer && !last) begin
            t_reg <= t_comb;
        end
    end

    assign t_use = t_reg;
`else
    assign t_use = t_comb;
`endif

    assign n0       = w0 ^ t_use;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign key_next = {n0, n1, n2, n3};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = EMIT;
            end
            EMIT: begin
                if (xfer) begin
                    if (last) begin
                        state_next = IDLE;
                    end else begin
`ifdef AES_KEYEXP_PIPE_EN
                        state_next = PIPE_WAIT;
`else
                        state_next = EMIT;
`endif
                    end
                end
            end
`ifdef AES_KEYEXP_PIPE_EN
            PIPE_WAIT: state_next = EMIT;
`endif
            default: state_next = IDLE;
        endcase
    end

    // Key / round datapath. key_reg is left untouched by the final transfer
    // so round_key keeps showing the round-10 key afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg   <= 128'h0;
            round_reg <= 4'd0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= xfer && last;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        key_reg   <= key;
                        round_reg <= 4'd0;
                    end
                end
                EMIT: begin
`ifndef AES_KEYEXP_PIPE_EN
                    if (xfer && !last) begin
                        key_reg   <= key_next;
                        round_reg <= round_reg + 4'd1;
                    end
`endif
                end
`ifdef AES_KEYEXP_PIPE_EN
                PIPE_WAIT: begin
                    key_reg   <= key_next;
                    round_reg <= round_reg + 4'd1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign rk_valid  = (state_reg == EMIT);
    assign busy      = (state_reg != IDLE);
    assign round_key = key_reg;
    assign rk_round  = round_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_aes_key_expand.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expand
//
// Self-checking bench for aes_key_expand. Expected round keys are pushed to a
// scoreboard queue when an expansion is started and popped by a monitor on
// every valid/ready transfer. Scenario tasks add their own timing checks.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Build with AES_KEYEXP_PIPE_EN to exercise the pipelined path.
// -----------------------------------------------------------------------------
module tb_aes_key_expand;

`ifdef AES_KEYEXP_PIPE_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] Z1       = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z10      = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
        bit           chk;
    } sb_entry_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;
    sb_entry_t sb[$];

    aes_key_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .rk_round  (rk_round),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Scoreboard monitor: one line per transfer
    always @(negedge clk) begin
        if (rst_n && rk_valid && rk_ready) begin
            $display("xfer round=%0d key=%h", rk_round, round_key);
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: unexpected transfer round=%0d, required none", rk_round);
            end else begin
                sb_entry_t e;
                e = sb.pop_front();
                if (rk_round !== e.rnd) begin
                    n_fail++;
                    $display("FAIL sb_round: got %0d required %0d", rk_round, e.rnd);
                end
                if (e.chk) begin
                    n_checks++;
                    if (round_key !== e.key) begin
                        n_fail++;
                        $display("FAIL sb_key r%0d: got %h required %h", e.rnd, round_key, e.key);
                    end
                end
            end
        end
    end

    task automatic push_fips();
        sb_entry_t e;
        for (int k = 0; k <= 10; k++) begin
            e.rnd = 4'(k);
            e.key = FIPS_RK[k];
            e.chk = 1'b1;
            sb.push_back(e);
        end
    endtask

    task automatic push_zero();
        sb_entry_t e;
        for (int k = 0; k <= 10; k++) begin
            e.rnd = 4'(k);
            e.key = (k == 0) ? ZERO_KEY : ((k == 1) ? Z1 : Z10);
            e.chk = (k <= 1) || (k == 10);
            sb.push_back(e);
        end
    endtask

    // Returns 1 time unit after the edge on which start is accepted.
    task automatic issue_start(input logic [127:0] k);
        @(posedge clk);
        #1;
        start = 1'b1;
        key   = k;
        @(posedge clk);
        #1;
        start = 1'b0;
        key   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        key      = 128'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rk_valid, busy, done, rk_round} !== 7'd0 || round_key !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b busy=%b done=%b round=%0d key=%h required all zero",
                     rk_valid, busy, done, rk_round, round_key);
        end
        rst_n = 1'b1;
        // rk_ready without a valid key must not start anything
        @(posedge clk);
        #1;
        rk_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || rk_round !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_ready: got valid=%b busy=%b round=%0d required 0 0 0",
                     rk_valid, busy, rk_round);
        end
        rk_ready = 1'b0;
    endtask

    // Full-rate FIPS expansion, then a new start on the done cycle (zero key).
    task automatic test_back_to_back();
        int  p;
        bit  exp_done, exp_valid;
        push_fips();
        rk_ready = 1'b1;
        issue_start(FIPS_KEY);
        for (int c = 0; c <= 20*S + 3; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            start = (c == 10*S + 1);
            if (start) begin
                key = ZERO_KEY;
                push_zero();
            end
            @(negedge clk);
            exp_done  = (c == 10*S + 1) || (c == 20*S + 3);
            p         = (c <= 10*S + 1) ? c : c - (10*S + 2);
            exp_valid = !exp_done && (p % S == 0);
            n_checks++;
            if (rk_valid !== exp_valid || busy !== !exp_done || done !== exp_done) begin
                n_fail++;
                $display("FAIL b2b_ctrl c=%0d: got valid=%b busy=%b done=%b required %b %b %b",
                         c, rk_valid, busy, done, exp_valid, !exp_done, exp_done);
            end
            if (exp_valid) begin
                n_checks++;
                if (rk_round !== 4'(p / S)) begin
                    n_fail++;
                    $display("FAIL b2b_round c=%0d: got %0d required %0d", c, rk_round, p / S);
                end
            end
        end
        start    = 1'b0;
        rk_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random_ready();
        bit           seen_done = 0, have_prev = 0;
        bit           prev_valid, prev_ready;
        logic [127:0] prev_key;
        logic [3:0]   prev_round;
        int           xfers = 0;
        push_fips();
        issue_start(FIPS_KEY);
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            rk_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (have_prev && prev_valid && !prev_ready) begin
                n_checks++;
                if (rk_valid !== 1'b1 || round_key !== prev_key || rk_round !== prev_round) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%b round=%0d key=%h required 1 %0d %h",
                             rk_valid, rk_round, round_key, prev_round, prev_key);
                end
            end
            if (rk_valid && rk_ready) xfers++;
            if (done) begin
                seen_done = 1;
                break;
            end
            have_prev  = 1;
            prev_valid = rk_valid;
            prev_ready = rk_ready;
            prev_key   = round_key;
            prev_round = rk_round;
        end
        n_checks++;
        if (!seen_done || xfers != 11) begin
            n_fail++;
            $display("FAIL random_ready: got done_seen=%0d transfers=%0d required 1 11", seen_done, xfers);
        end
        rk_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_ignored();
        bit fired = 0, seen_done = 0;
        push_fips();
        rk_ready = 1'b1;
        issue_start(FIPS_KEY);
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            start = 1'b0;
            @(negedge clk);
            if (done) begin
                seen_done = 1;
                break;
            end
            if (rk_valid && rk_round == 4'd4 && !fired) begin
                #1;
                start = 1'b1;
                key   = ZERO_KEY;
                fired = 1;
            end
        end
        start = 1'b0;
        n_checks++;
        if (!seen_done || !fired) begin
            n_fail++;
            $display("FAIL start_ignored_run: got done_seen=%0d start_fired=%0d required 1 1", seen_done, fired);
        end
        n_checks++;
        if (round_key !== FIPS_RK[10] || rk_round !== 4'd10) begin
            n_fail++;
            $display("FAIL start_ignored_final: got r%0d %h required r10 %h", rk_round, round_key, FIPS_RK[10]);
        end
        rk_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Reset mid-expansion, then restart with the all-zero key
    task automatic test_reset_mid();
        bit hit = 0, seen_done = 0;
        push_fips();
        rk_ready = 1'b1;
        issue_start(FIPS_KEY);
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            if (rk_valid && rk_round == 4'd6) begin
                hit = 1;
                break;
            end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reset_mid_reach: round 6 not observed, required observed");
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || round_key !== 128'h0 || rk_round !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_async: got valid=%b busy=%b round=%0d key=%h required 0 0 0 0",
                     rk_valid, busy, rk_round, round_key);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        n_checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got valid=%b busy=%b required 0 0", rk_valid, busy);
        end
        rst_n = 1'b1;
        push_zero();
        issue_start(ZERO_KEY);
        @(negedge clk);
        n_checks++;
        if (rk_valid !== 1'b1 || rk_round !== 4'd0 || round_key !== ZERO_KEY) begin
            n_fail++;
            $display("FAIL restart: got valid=%b round=%0d key=%h required 1 0 %h",
                     rk_valid, rk_round, round_key, ZERO_KEY);
        end
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (done) begin
                seen_done = 1;
                break;
            end
        end
        n_checks++;
        if (!seen_done || round_key !== Z10) begin
            n_fail++;
            $display("FAIL zero_key_final: got done_seen=%0d key=%h required 1 %h", seen_done, round_key, Z10);
        end
        rk_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_random_ready();
        test_start_ignored();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending entries required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
